lsb_rr_arbiter: RTL and testbench
=================================

LSB_RR_ARBITER -- requirements
Module: lsb_rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, number of requesters (>=2).
REQ-002 Parameter MAX_HOLD, default 8, maximum grant length in cycles (>=1).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 req  input  WIDTH  per-requester request level; bit i = requester i.
REQ-006 done  input  1  current owner releases the resource this cycle.
REQ-007 gnt  output  WIDTH  one-hot grant, registered; all-zero = no owner.
REQ-008 gnt_id  output  $clog2(WIDTH)  index of granted requester; 0 when gnt is zero.
REQ-009 timeout  output  1  one-cycle pulse marking a forced release.

Function
REQ-010 FSM states: IDLE and GRANT; reset state IDLE.
REQ-011 Round-robin pointer ptr, $clog2(WIDTH) bits, reset 0, marks the highest-priority requester.
REQ-012 Selection in IDLE: lowest set bit of req at index >= ptr. If none, lowest set bit of req overall (wrap-around).
REQ-013 Selection uses LSB-first priority encoding: req=0110 with ptr=0 selects index 1.
REQ-014 IDLE with req!=0: next cycle state=GRANT; gnt=one-hot(sel); gnt_id=sel. Latency is 1 cycle.
REQ-015 IDLE with req==0: stay IDLE; gnt=0; gnt_id=0.
REQ-016 Hold counter resets to 1 on GRANT entry and increments each cycle the FSM stays in GRANT.
REQ-017 Release conditions in GRANT:
- done=1, or
- req[gnt_id]=0, or
- hold counter == MAX_HOLD.
REQ-018 On release: next cycle state=IDLE; gnt=0; gnt_id=0; ptr=(owner+1) mod WIDTH.
REQ-019 After every release there is at least one IDLE cycle. No back-to-back grants without a zero-gnt cycle.
REQ-020 timeout=1 only in the IDLE cycle following a release caused solely by the hold limit.
REQ-021 If done or a dropped req coincides with the hold limit, the release is normal and timeout=0.
REQ-022 In GRANT, changes in non-owner req bits are ignored. They are evaluated only in IDLE.
REQ-023 done asserted in IDLE is ignored.
REQ-024 gnt is always zero or one-hot; gnt_id always matches gnt.

Reset
REQ-025 rst_n low asynchronously forces the following, including mid-grant: state=IDLE, ptr=0, hold counter=0, gnt=0, gnt_id=0, timeout=0.
REQ-026 On the first edge after rst_n deasserts, the block arbitrates normally from ptr=0.

Structure
REQ-027 Shared package lsb_arb_pkg holds the FSM state enum (IDLE, GRANT) and default parameter constants.
REQ-028 One sub-module, lsb_prio_enc: combinational, WIDTH-parameterized, LSB-first priority encoder built with a for loop.
REQ-029 lsb_prio_enc outputs a found flag and an index. The arbiter instantiates it twice, for the masked and the unmasked selection.
REQ-030 No latches; all outputs come from flops.

Verification (WIDTH=4, MAX_HOLD=8)
REQ-031 Reset: rst_n=0 during active grant -> gnt=0000, gnt_id=0, timeout=0 immediately, before any clock edge; ptr=0 after release.
REQ-032 Basic grant: ptr=0, req=0110 -> next cycle gnt=0010, gnt_id=1. Then done=1 -> next cycle gnt=0000, ptr=2. Then gnt=0100.
REQ-033 Wrap-around: ptr=3, req=0011 -> gnt=0001, gnt_id=0. After release, ptr=1.
REQ-034 Timeout: req=1000 held, done=0 -> gnt=1000 for exactly 8 cycles. Then gnt=0000 with timeout=1 for one cycle, ptr=0.
REQ-035 Dropped request: owner 2 deasserts req[2] on 3rd grant cycle -> next cycle gnt=0000, timeout=0, ptr=3.
REQ-036 Fairness: req=1111 held, done pulsed each grant -> grants rotate 0001,0010,0100,1000,0001, each separated by one zero cycle.

Source files
------------

// File: rtl/lsb_arb_pkg.sv
// rtl/lsb_arb_pkg.sv - shared FSM state type and default sizing for the LSB round-robin arbiter
package lsb_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/lsb_prio_enc.sv
// rtl/lsb_prio_enc.sv - combinational LSB-first priority encoder with found flag
module lsb_prio_enc
    import lsb_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0]         req_i,
    output logic                     found_o,
    output logic [$clog2(WIDTH)-1:0] idx_o
);

    localparam int IW = $clog2(WIDTH);

    // The found guard makes the lowest set bit win.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (req_i[i] && !found_o) begin
                found_o = 1'b1;
                idx_o   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/lsb_rr_arbiter.sv
// rtl/lsb_rr_arbiter.sv - round-robin arbiter with LSB-first selection, hold limit and timeout pulse
module lsb_rr_arbiter
    import lsb_arb_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         req,
    input  logic                     done,
    output logic [WIDTH-1:0]         gnt,
    output logic [$clog2(WIDTH)-1:0] gnt_id,
    output logic                     timeout
);

    localparam int               IW         = $clog2(WIDTH);
    localparam int               CW         = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0]    HOLD_LIMIT = CW'(MAX_HOLD);
    localparam logic [IW-1:0]    LAST_ID    = IW'(WIDTH - 1);

    arb_state_e       state_q;
    logic [IW-1:0]    ptr_q;
    logic [IW-1:0]    ptr_d;
    logic [IW-1:0]    gnt_id_q;
    logic [WIDTH-1:0] gnt_q;
    logic [CW-1:0]    hold_q;
    logic [CW-1:0]    hold_d;
    logic             timeout_q;

    logic [WIDTH-1:0] prio_mask;
    logic [WIDTH-1:0] masked_req;
    logic             m_found;
    logic [IW-1:0]    m_idx;
    logic             u_found;
    logic [IW-1:0]    u_idx;
    logic [IW-1:0]    sel_d;
    logic [WIDTH-1:0] gnt_d;
    logic             owner_req;
    logic             at_limit;
    logic             release_now;
    logic             timeout_d;

    // Only requesters at or above the pointer take part in the first pass.
    always_comb begin
        prio_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            prio_mask[i] = (IW'(i) >= ptr_q);
        end
    end

    assign masked_req = req & prio_mask;

    lsb_prio_enc #(.WIDTH(WIDTH)) u_masked_enc (
        .req_i   (masked_req),
        .found_o (m_found),
        .idx_o   (m_idx)
    );

    lsb_prio_enc #(.WIDTH(WIDTH)) u_unmasked_enc (
        .req_i   (req),
        .found_o (u_found),
        .idx_o   (u_idx)
    );

    assign sel_d       = m_found ? m_idx : u_idx;
    assign gnt_d       = WIDTH'(1) << sel_d;
    assign owner_req   = req[gnt_id_q];
    assign at_limit    = (hold_q == HOLD_LIMIT);
    assign release_now = done || !owner_req || at_limit;
    assign timeout_d   = at_limit && !done && owner_req;
    assign hold_d      = hold_q + 1'b1;
    assign ptr_d       = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    timeout_q <= 1'b0;
                    if (u_found) begin
                        state_q  <= GRANT;
                        gnt_q    <= gnt_d;
                        gnt_id_q <= sel_d;
                        hold_q   <= CW'(1);
                    end else begin
                        gnt_q    <= '0;
                        gnt_id_q <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state_q   <= IDLE;
                        gnt_q     <= '0;
                        gnt_id_q  <= '0;
                        ptr_q     <= ptr_d;
                        hold_q    <= '0;
                        timeout_q <= timeout_d;
                    end else begin
                        hold_q    <= hold_d;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    gnt_q     <= '0;
                    gnt_id_q  <= '0;
                    hold_q    <= '0;
                    timeout_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_lsb_rr_arbiter.sv
// tb/tb_lsb_rr_arbiter.sv - directed self-checking bench for lsb_rr_arbiter
module tb_lsb_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       timeout;

    int n_checks;
    int n_fails;

    lsb_rr_arbiter #(.WIDTH(4), .MAX_HOLD(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        #12;
        n_checks++;
        if ({gnt, gnt_id, timeout} !== 7'b0000_00_0) begin
            n_fails++;
            $display("FAIL reset_outputs: gnt=%b id=%0d to=%b, required 0000/0/0", gnt, gnt_id, timeout);
        end
        n_checks++;
        if (dut.ptr_q !== 2'd0) begin
            n_fails++;
            $display("FAIL reset_ptr: ptr=%0d, required 0", dut.ptr_q);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (gnt !== 4'b0000) begin
            n_fails++;
            $display("FAIL reset_idle: gnt=%b, required 0000", gnt);
        end
    endtask

    task automatic test_basic();
        req = 4'b0110;
        step();
        n_checks++;
        if ({gnt, gnt_id} !== {4'b0010, 2'd1}) begin
            n_fails++;
            $display("FAIL basic_grant: gnt=%b id=%0d, required 0010/1", gnt, gnt_id);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        n_checks++;
        if ({gnt, gnt_id, timeout, dut.ptr_q} !== {4'b0000, 2'd0, 1'b0, 2'd2}) begin
            n_fails++;
            $display("FAIL basic_release: gnt=%b id=%0d to=%b ptr=%0d, required 0000/0/0/2", gnt, gnt_id, timeout, dut.ptr_q);
        end
        step();
        n_checks++;
        if ({gnt, gnt_id} !== {4'b0100, 2'd2}) begin
            n_fails++;
            $display("FAIL basic_next: gnt=%b id=%0d, required 0100/2", gnt, gnt_id);
        end
        done = 1'b1;
        req  = 4'b0000;
        step();
        done = 1'b0;
        n_checks++;
        if ({gnt, timeout, dut.ptr_q} !== {4'b0000, 1'b0, 2'd3}) begin
            n_fails++;
            $display("FAIL basic_release2: gnt=%b to=%b ptr=%0d, required 0000/0/3", gnt, timeout, dut.ptr_q);
        end
    endtask

    task automatic test_wrap();
        req = 4'b0011;
        step();
        n_checks++;
        if ({gnt, gnt_id} !== {4'b0001, 2'd0}) begin
            n_fails++;
            $display("FAIL wrap_grant: gnt=%b id=%0d, required 0001/0", gnt, gnt_id);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 4'b0000;
        n_checks++;
        if ({gnt, dut.ptr_q} !== {4'b0000, 2'd1}) begin
            n_fails++;
            $display("FAIL wrap_release: gnt=%b ptr=%0d, required 0000/1", gnt, dut.ptr_q);
        end
        step();
    endtask

    task automatic test_timeout();
        req = 4'b1000;
        for (int c = 1; c <= 8; c++) begin
            step();
            n_checks++;
            if ({gnt, gnt_id, timeout} !== {4'b1000, 2'd3, 1'b0}) begin
                n_fails++;
                $display("FAIL timeout_hold[%0d]: gnt=%b id=%0d to=%b, required 1000/3/0", c, gnt, gnt_id, timeout);
            end
        end
        step();
        req = 4'b0000;
        n_checks++;
        if ({gnt, timeout, dut.ptr_q} !== {4'b0000, 1'b1, 2'd0}) begin
            n_fails++;
            $display("FAIL timeout_pulse: gnt=%b to=%b ptr=%0d, required 0000/1/0", gnt, timeout, dut.ptr_q);
        end
        step();
        n_checks++;
        if ({gnt, timeout} !== {4'b0000, 1'b0}) begin
            n_fails++;
            $display("FAIL timeout_one_cycle: gnt=%b to=%b, required 0000/0", gnt, timeout);
        end
    endtask

    task automatic test_drop();
        req = 4'b0100;
        step();
        step();
        step();
        n_checks++;
        if ({gnt, gnt_id} !== {4'b0100, 2'd2}) begin
            n_fails++;
            $display("FAIL drop_grant: gnt=%b id=%0d, required 0100/2", gnt, gnt_id);
        end
        req = 4'b0000;
        step();
        n_checks++;
        if ({gnt, timeout, dut.ptr_q} !== {4'b0000, 1'b0, 2'd3}) begin
            n_fails++;
            $display("FAIL drop_release: gnt=%b to=%b ptr=%0d, required 0000/0/3", gnt, timeout, dut.ptr_q);
        end
    endtask

    task automatic test_limit_with_done();
        req = 4'b1000;
        for (int c = 1; c <= 8; c++) step();
        n_checks++;
        if (gnt !== 4'b1000) begin
            n_fails++;
            $display("FAIL limit_done_grant: gnt=%b, required 1000", gnt);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 4'b0000;
        n_checks++;
        if ({gnt, timeout, dut.ptr_q} !== {4'b0000, 1'b0, 2'd0}) begin
            n_fails++;
            $display("FAIL limit_done_release: gnt=%b to=%b ptr=%0d, required 0000/0/0", gnt, timeout, dut.ptr_q);
        end
    endtask

    task automatic test_ignored_inputs();
        done = 1'b1;
        step();
        done = 1'b0;
        n_checks++;
        if ({gnt, dut.ptr_q} !== {4'b0000, 2'd0}) begin
            n_fails++;
            $display("FAIL idle_done: gnt=%b ptr=%0d, required 0000/0", gnt, dut.ptr_q);
        end
        req = 4'b0001;
        step();
        req = 4'b1111;
        step();
        step();
        n_checks++;
        if ({gnt, gnt_id} !== {4'b0001, 2'd0}) begin
            n_fails++;
            $display("FAIL non_owner_ignored: gnt=%b id=%0d, required 0001/0", gnt, gnt_id);
        end
        req  = 4'b0000;
        step();
        step();
    endtask

    task automatic test_reset_mid_grant();
        req = 4'b0010;
        step();
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_fails++;
            $display("FAIL mid_reset_pre: gnt=%b, required 0010", gnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({gnt, gnt_id, timeout, dut.ptr_q} !== {4'b0000, 2'd0, 1'b0, 2'd0}) begin
            n_fails++;
            $display("FAIL mid_reset_async: gnt=%b id=%0d to=%b ptr=%0d, required 0000/0/0/0", gnt, gnt_id, timeout, dut.ptr_q);
        end
        step();
        req   = 4'b1010;
        rst_n = 1'b1;
        step();
        n_checks++;
        if ({gnt, gnt_id} !== {4'b0010, 2'd1}) begin
            n_fails++;
            $display("FAIL post_reset_grant: gnt=%b id=%0d, required 0010/1", gnt, gnt_id);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 4'b0000;
        step();
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_gnt;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_gnt = 4'b0001 << (k % 4);
            step();
            n_checks++;
            if ({gnt, gnt_id} !== {exp_gnt, 2'(k % 4)}) begin
                n_fails++;
                $display("FAIL fair_grant[%0d]: gnt=%b id=%0d, required %b/%0d", k, gnt, gnt_id, exp_gnt, k % 4);
            end
            done = 1'b1;
            step();
            done = 1'b0;
            n_checks++;
            if (gnt !== 4'b0000) begin
                n_fails++;
                $display("FAIL fair_gap[%0d]: gnt=%b, required 0000", k, gnt);
            end
        end
        req = 4'b0000;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_timeout();
        test_drop();
        test_limit_with_done();
        test_ignored_inputs();
        test_reset_mid_grant();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
